// File: rtl/inst_decode.sv
// ARM32 ID stage: register file, condition check, control decode and ID/EXE register (1-cycle latency).
// Optional macro REGFILE_BYPASS_EN makes a same-cycle WB write visible to reads.
module inst_decode #(
    parameter int REG_COUNT = 15,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction_ID,
    input  logic [DATA_W-1:0] pc_ID,
    input  logic              hazard,
    input  logic              B_EXE,
    input  logic [3:0]        status,
    input  logic              wb_en_WB,
    input  logic [3:0]        wb_dest_WB,
    input  logic [DATA_W-1:0] wb_value_WB,
    output logic              two_src,
    output logic [3:0]        src1,
    output logic [3:0]        src2,
    output logic [DATA_W-1:0] pc_EXE,
    output logic [DATA_W-1:0] val_Rn_EXE,
    output logic [DATA_W-1:0] val_Rm_EXE,
    output logic [11:0]       shift_operand_EXE,
    output logic [23:0]       signed_imm_24_EXE,
    output logic              imm_EXE,
    output logic [3:0]        dest_EXE,
    output logic [3:0]        src1_EXE,
    output logic [3:0]        src2_EXE,
    output logic [3:0]        exe_cmd_EXE,
    output logic              mem_r_en_EXE,
    output logic              mem_w_en_EXE,
    output logic              wb_en_EXE,
    output logic              B_EXE_out,
    output logic              S_EXE
);
    logic [DATA_W-1:0] r_regs [REG_COUNT];

    logic [3:0] w_cond, w_opcode, w_rn, w_rd, w_rm;
    logic [1:0] w_mode;
    logic       w_ibit, w_sbit, w_str, w_wb_ok;

    assign w_cond   = instruction_ID[31:28];
    assign w_mode   = instruction_ID[27:26];
    assign w_ibit   = instruction_ID[25];
    assign w_opcode = instruction_ID[24:21];
    assign w_sbit   = instruction_ID[20];
    assign w_rn     = instruction_ID[19:16];
    assign w_rd     = instruction_ID[15:12];
    assign w_rm     = instruction_ID[3:0];

    assign w_str    = (w_mode == 2'b01) && !w_sbit;
    assign w_wb_ok  = wb_en_WB && (32'(wb_dest_WB) < REG_COUNT);
    assign src1     = w_rn;
    assign src2     = w_str ? w_rd : w_rm;
    assign two_src  = ((w_mode == 2'b00) && !w_ibit) || w_str;

    // R15 is not stored; reading it yields zero
    logic [DATA_W-1:0] w_rn_val, w_rm_val;
    always_comb begin
        w_rn_val = '0;
        w_rm_val = '0;
        if (32'(w_rn) < REG_COUNT) w_rn_val = r_regs[w_rn];
        if (32'(src2) < REG_COUNT) w_rm_val = r_regs[src2];
`ifdef REGFILE_BYPASS_EN
        if (w_wb_ok && (wb_dest_WB == w_rn)) w_rn_val = wb_value_WB;
        if (w_wb_ok && (wb_dest_WB == src2)) w_rm_val = wb_value_WB;
`endif
    end

    logic w_n, w_z, w_c, w_v, w_cond_ok;
    assign {w_n, w_z, w_c, w_v} = status;
    always_comb begin
        case (w_cond)
            4'b0000: w_cond_ok = w_z;
            4'b0001: w_cond_ok = !w_z;
            4'b0010: w_cond_ok = w_c;
            4'b0011: w_cond_ok = !w_c;
            4'b0100: w_cond_ok = w_n;
            4'b0101: w_cond_ok = !w_n;
            4'b0110: w_cond_ok = w_v;
            4'b0111: w_cond_ok = !w_v;
            4'b1000: w_cond_ok = w_c && !w_z;
            4'b1001: w_cond_ok = !w_c || w_z;
            4'b1010: w_cond_ok = (w_n == w_v);
            4'b1011: w_cond_ok = (w_n != w_v);
            4'b1100: w_cond_ok = !w_z && (w_n == w_v);
            4'b1101: w_cond_ok = w_z || (w_n != w_v);
            4'b1110: w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    logic [3:0] w_cmd;
    logic       w_mr, w_mw, w_wb, w_b, w_s;
    always_comb begin
        w_cmd = '0;
        w_mr  = 1'b0;
        w_mw  = 1'b0;
        w_wb  = 1'b0;
        w_b   = 1'b0;
        w_s   = 1'b0;
        case (w_mode)
            2'b00: begin
                w_wb = 1'b1;
                w_s  = w_sbit;
                case (w_opcode)
                    4'b1101: w_cmd = 4'b0001;
                    4'b1111: w_cmd = 4'b1001;
                    4'b0100: w_cmd = 4'b0010;
                    4'b0101: w_cmd = 4'b0011;
                    4'b0010: w_cmd = 4'b0100;
                    4'b0110: w_cmd = 4'b0101;
                    4'b0000: w_cmd = 4'b0110;
                    4'b1100: w_cmd = 4'b0111;
                    4'b0001: w_cmd = 4'b1000;
                    4'b1010: begin w_cmd = 4'b0100; w_wb = 1'b0; w_s = 1'b1; end
                    4'b1000: begin w_cmd = 4'b0110; w_wb = 1'b0; w_s = 1'b1; end
                    default: begin w_wb = 1'b0; w_s = 1'b0; end
                endcase
            end
            2'b01: begin
                w_cmd = 4'b0010;
                w_mr  = w_sbit;
                w_wb  = w_sbit;
                w_mw  = !w_sbit;
            end
            2'b10:   w_b = 1'b1;
            default: ;
        endcase
    end

    logic w_bubble;
    assign w_bubble = !w_cond_ok || hazard;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
        end else if (w_wb_ok) begin
            r_regs[wb_dest_WB] <= wb_value_WB;
        end
    end

    // Flush beats bubble; a bubble keeps data fields but kills every control bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || B_EXE) begin
            if (!rst || B_EXE) begin
                pc_EXE            <= '0;
                val_Rn_EXE        <= '0;
                val_Rm_EXE        <= '0;
                shift_operand_EXE <= '0;
                signed_imm_24_EXE <= '0;
                imm_EXE           <= 1'b0;
                dest_EXE          <= '0;
                src1_EXE          <= '0;
                src2_EXE          <= '0;
                exe_cmd_EXE       <= '0;
                mem_r_en_EXE      <= 1'b0;
                mem_w_en_EXE      <= 1'b0;
                wb_en_EXE         <= 1'b0;
                B_EXE_out         <= 1'b0;
                S_EXE             <= 1'b0;
            end
        end else begin
            pc_EXE            <= pc_ID;
            val_Rn_EXE        <= w_rn_val;
            val_Rm_EXE        <= w_rm_val;
            shift_operand_EXE <= instruction_ID[11:0];
            signed_imm_24_EXE <= instruction_ID[23:0];
            imm_EXE           <= w_ibit;
            dest_EXE          <= w_rd;
            src1_EXE          <= w_rn;
            src2_EXE          <= src2;
            exe_cmd_EXE       <= w_bubble ? 4'b0000 : w_cmd;
            mem_r_en_EXE      <= w_mr && !w_bubble;
            mem_w_en_EXE      <= w_mw && !w_bubble;
            wb_en_EXE         <= w_wb && !w_bubble;
            B_EXE_out         <= w_b && !w_bubble;
            S_EXE             <= w_s && !w_bubble;
        end
    end
endmodule

// File: tb/tb_inst_decode.sv
// Randomised scoreboard bench for inst_decode against an instruction-level reference model.
module tb_inst_decode;
    logic        clk, rst, hazard, B_EXE, wb_en_WB;
    logic [31:0] instruction_ID, pc_ID, wb_value_WB;
    logic [3:0]  status, wb_dest_WB;
    logic        two_src;
    logic [3:0]  src1, src2;
    logic [31:0] pc_EXE, val_Rn_EXE, val_Rm_EXE;
    logic [11:0] shift_operand_EXE;
    logic [23:0] signed_imm_24_EXE;
    logic        imm_EXE;
    logic [3:0]  dest_EXE, src1_EXE, src2_EXE, exe_cmd_EXE;
    logic        mem_r_en_EXE, mem_w_en_EXE, wb_en_EXE, B_EXE_out, S_EXE;

    inst_decode dut (
        .clk(clk), .rst(rst), .instruction_ID(instruction_ID), .pc_ID(pc_ID),
        .hazard(hazard), .B_EXE(B_EXE), .status(status), .wb_en_WB(wb_en_WB),
        .wb_dest_WB(wb_dest_WB), .wb_value_WB(wb_value_WB), .two_src(two_src),
        .src1(src1), .src2(src2), .pc_EXE(pc_EXE), .val_Rn_EXE(val_Rn_EXE),
        .val_Rm_EXE(val_Rm_EXE), .shift_operand_EXE(shift_operand_EXE),
        .signed_imm_24_EXE(signed_imm_24_EXE), .imm_EXE(imm_EXE), .dest_EXE(dest_EXE),
        .src1_EXE(src1_EXE), .src2_EXE(src2_EXE), .exe_cmd_EXE(exe_cmd_EXE),
        .mem_r_en_EXE(mem_r_en_EXE), .mem_w_en_EXE(mem_w_en_EXE), .wb_en_EXE(wb_en_EXE),
        .B_EXE_out(B_EXE_out), .S_EXE(S_EXE)
    );

    typedef struct packed {
        logic [31:0] pc, rn, rm;
        logic [11:0] sh;
        logic [23:0] imm24;
        logic        imm;
        logic [3:0]  dest, s1, s2, cmd;
        logic        mr, mw, wb, b, s;
    } exp_t;

    exp_t        exp_q[$];
    string       tag_q[$];
    logic [31:0] m_regs [15];
    int          n_cmp = 0;
    int          n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t actual();
        return {pc_EXE, val_Rn_EXE, val_Rm_EXE, shift_operand_EXE, signed_imm_24_EXE, imm_EXE,
                dest_EXE, src1_EXE, src2_EXE, exe_cmd_EXE, mem_r_en_EXE, mem_w_en_EXE,
                wb_en_EXE, B_EXE_out, S_EXE};
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] idx);
        if (idx == 4'd15) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wb_en_WB && wb_dest_WB != 4'd15 && wb_dest_WB == idx) return wb_value_WB;
`endif
        return m_regs[idx];
    endfunction

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] nzcv);
        bit n, z, cy, v;
        {n, z, cy, v} = nzcv;
        case (c)
            0: return z;           1: return !z;
            2: return cy;          3: return !cy;
            4: return n;           5: return !n;
            6: return v;           7: return !v;
            8: return cy && !z;    9: return !cy || z;
            10: return n == v;     11: return n != v;
            12: return !z && n == v;
            13: return z || n != v;
            14: return 1;
            default: return 0;
        endcase
    endfunction

    // ALU command per data-processing mnemonic; -1 marks an undefined opcode
    function automatic int alu_cmd(input logic [3:0] opc);
        case (opc)
            4'hD: return 1;  4'hF: return 9;  4'h4: return 2;  4'h5: return 3;
            4'h2: return 4;  4'h6: return 5;  4'h0: return 6;  4'hC: return 7;
            4'h1: return 8;  4'hA: return 4;  4'h8: return 6;
            default: return -1;
        endcase
    endfunction

    function automatic exp_t model();
        exp_t e;
        logic [31:0] in;
        int mode, cmd;
        bit s_bit, is_str, is_cmp_tst;
        e = '0;
        if (B_EXE) return e;
        in = instruction_ID;
        mode = int'(in[27:26]);
        s_bit = in[20];
        is_str = (mode == 1) && !s_bit;
        e.pc = pc_ID;
        e.sh = in[11:0];
        e.imm24 = in[23:0];
        e.imm = in[25];
        e.dest = in[15:12];
        e.s1 = in[19:16];
        e.s2 = is_str ? in[15:12] : in[3:0];
        e.rn = m_read(e.s1);
        e.rm = m_read(e.s2);
        if (hazard || !cond_holds(in[31:28], status)) return e;
        if (mode == 0) begin
            cmd = alu_cmd(in[24:21]);
            is_cmp_tst = (in[24:21] == 4'hA) || (in[24:21] == 4'h8);
            if (cmd >= 0) begin
                e.cmd = 4'(cmd);
                e.wb = !is_cmp_tst;
                e.s = is_cmp_tst ? 1'b1 : s_bit;
            end
        end else if (mode == 1) begin
            e.cmd = 4'd2;
            e.mr = s_bit;
            e.wb = s_bit;
            e.mw = !s_bit;
        end else if (mode == 2) begin
            e.b = 1'b1;
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic hz,
                         input logic fl, input logic [3:0] st, input logic wen,
                         input logic [3:0] wdest, input logic [31:0] wval, input string tag);
        bit exp_two;
        logic [3:0] exp_s2;
        @(negedge clk);
        instruction_ID = inst; pc_ID = pc; hazard = hz; B_EXE = fl; status = st;
        wb_en_WB = wen; wb_dest_WB = wdest; wb_value_WB = wval;
        #1;
        exp_two = (inst[27:26] == 2'b00 && !inst[25]) || (inst[27:26] == 2'b01 && !inst[20]);
        exp_s2 = (inst[27:26] == 2'b01 && !inst[20]) ? inst[15:12] : inst[3:0];
        n_cmp++;
        if (two_src !== exp_two || src1 !== inst[19:16] || src2 !== exp_s2) begin
            n_fail++;
            $display("FAIL %s comb: got two_src=%b src1=%h src2=%h want %b %h %h",
                     tag, two_src, src1, src2, exp_two, inst[19:16], exp_s2);
        end
        exp_q.push_back(model());
        tag_q.push_back(tag);
        if (wen && wdest != 4'd15) m_regs[wdest] = wval;
    endtask

    task automatic quiet();
        @(negedge clk);
        wb_en_WB = 1'b0; hazard = 1'b0; B_EXE = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        n_cmp++;
        if (actual() !== '0) begin
            n_fail++;
            $display("FAIL %s: got %h want all zero", tag, actual());
        end
    endtask

    initial begin : monitor
        exp_t e;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                n_cmp++;
                if (actual() !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h want %h", t, actual(), e);
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b0; instruction_ID = 32'hE0821003; pc_ID = 32'h100; hazard = 1'b0;
        B_EXE = 1'b0; status = 4'h0; wb_en_WB = 1'b0; wb_dest_WB = 4'd0; wb_value_WB = 32'h0;
        for (int i = 0; i < 15; i++) m_regs[i] = 32'h0;
        #2 check_zero("reset_state");
        @(posedge clk); #1 check_zero("reset_hold");
        @(negedge clk); rst = 1'b1;

        issue(32'hF0000000, 32'h0, 0, 0, 4'h0, 1, 4'd2, 32'd5, "wr_r2");
        issue(32'hF0000000, 32'h0, 0, 0, 4'h0, 1, 4'd3, 32'd7, "wr_r3");
        issue(32'hE0821003, 32'h104, 0, 0, 4'h0, 0, 4'd0, 32'd0, "add_r1_r2_r3");
        issue(32'h03A00001, 32'h108, 0, 0, 4'h0, 0, 4'd0, 32'd0, "moveq_z0");
        issue(32'h03A00001, 32'h10C, 0, 0, 4'h4, 0, 4'd0, 32'd0, "moveq_z1");
        issue(32'hF0000000, 32'h0, 0, 0, 4'h0, 1, 4'd4, 32'h44, "wr_r4");
        issue(32'hE5854000, 32'h110, 1, 0, 4'h0, 0, 4'd0, 32'd0, "str_hazard");
        issue(32'hE5854000, 32'h114, 0, 0, 4'h0, 0, 4'd0, 32'd0, "str");
        issue(32'hE5954000, 32'h118, 0, 0, 4'h0, 0, 4'd0, 32'd0, "ldr");
        issue(32'hEA000010, 32'h11C, 0, 0, 4'h0, 0, 4'd0, 32'd0, "branch");
        issue(32'hE0821003, 32'h120, 0, 1, 4'h0, 0, 4'd0, 32'd0, "flush");
        issue(32'hE0821003, 32'h124, 1, 1, 4'h0, 0, 4'd0, 32'd0, "flush_hazard");
        issue(32'hE1520003, 32'h128, 0, 0, 4'h0, 0, 4'd0, 32'd0, "cmp");
        issue(32'hE0821003, 32'h12C, 0, 0, 4'h0, 1, 4'd2, 32'hDEAD, "wb_same_cycle");
        issue(32'hE0821003, 32'h130, 0, 0, 4'h0, 0, 4'd0, 32'd0, "wb_next_cycle");
        issue(32'hF0000000, 32'h0, 0, 0, 4'h0, 1, 4'd15, 32'hBAD, "wr_r15");
        issue(32'hE08F100F, 32'h134, 0, 0, 4'h0, 0, 4'd0, 32'd0, "read_r15");

        for (int i = 0; i < 400; i++) begin
            logic [31:0] inst;
            inst = $urandom;
            if ($urandom_range(1, 0) == 1) inst[31:28] = 4'hE;
            issue(inst, $urandom, ($urandom_range(4, 0) == 0), ($urandom_range(9, 0) == 0),
                  4'($urandom), $urandom_range(1, 0) == 1, 4'($urandom), $urandom, "random");
        end

        quiet();
        repeat (2) @(posedge clk);
        instruction_ID = 32'hE0821003;
        #3 rst = 1'b0;
        for (int i = 0; i < 15; i++) m_regs[i] = 32'h0;
        #1 check_zero("reset_midrun");
        @(posedge clk); #1 check_zero("reset_midrun_hold");
        @(negedge clk); rst = 1'b1;
        issue(32'hE0831003, 32'h200, 0, 0, 4'h0, 0, 4'd0, 32'd0, "r3_after_reset");
        for (int i = 0; i < 50; i++) begin
            issue($urandom, $urandom, 1'b0, 1'b0, 4'($urandom), 1'b1, 4'($urandom), $urandom,
                  "random_post_reset");
        end

        quiet();
        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
